// File: rtl/cpu_sequencer.sv
// Program sequencer for the cpu datapath: fetches 20-bit words from a synchronous ROM,
// issues datapath opcodes for one clock and executes jumps/halt internally with a step watchdog.
module cpu_sequencer #(
    parameter int PC_W      = 6,
    parameter int MAX_STEPS = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] prog_addr,
    input  logic [19:0]     prog_data,
    output logic [19:0]     instr,
    input  logic            zf,
    input  logic            sf,
    output logic            flag_z,
    output logic            flag_s,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [1:0]      fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    localparam logic [16:0] STEP_LIMIT = 17'(MAX_STEPS);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] target;
    logic [15:0]     steps;
    logic [16:0]     steps_inc;
    logic [3:0]      opcode;
    logic            is_datapath;
    logic            is_halt;
    logic            wd_trip;
    logic            after_issue;
    logic [19:0]     instr_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            timeout_nxt;

    assign prog_addr = pc;
    assign fsm_state = state;

    assign opcode      = prog_data[19:16];
    assign target      = prog_data[PC_W-1:0];
    assign pc_plus1    = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign steps_inc   = {1'b0, steps} + 17'd1;
    assign is_halt     = (opcode == 4'hF);
    assign is_datapath = (opcode inside {[4'h1:4'h8], 4'hB, 4'hC, 4'hD});
    // HALT always wins over the watchdog, even on the step that would trip it.
    assign wd_trip     = (steps_inc > STEP_LIMIT) && !is_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = DECODE;
            DECODE: begin
                if (wd_trip || is_halt) state_nxt = IDLE;
                else if (is_datapath)   state_nxt = ISSUE;
                else                    state_nxt = FETCH;
            end
            ISSUE:   state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt      = pc;
        instr_nxt   = 20'h00000;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        busy_nxt    = (state_nxt != IDLE);
        unique case (state)
            IDLE: if (start) pc_nxt = '0;
            DECODE: begin
                if (wd_trip) begin
                    timeout_nxt = 1'b1;
                end else if (is_halt) begin
                    done_nxt = 1'b1;
                end else if (is_datapath) begin
                    instr_nxt = prog_data;
                end else begin
                    case (opcode)
                        4'h9:    pc_nxt = target;
                        4'hA:    pc_nxt = flag_z ? target : pc_plus1;
                        4'hE:    pc_nxt = flag_s ? target : pc_plus1;
                        default: pc_nxt = pc_plus1;
                    endcase
                end
            end
            ISSUE:   pc_nxt = pc_plus1;
            default: pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            steps       <= '0;
            instr       <= 20'h00000;
            flag_z      <= 1'b0;
            flag_s      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            after_issue <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            after_issue <= (state == ISSUE);
            if (state == IDLE && start) begin
                steps  <= '0;
                flag_z <= 1'b0;
                flag_s <= 1'b0;
            end
            if (state == DECODE) steps <= steps_inc[15:0];
            // The cpu flags are only valid in the FETCH cycle right after an issue.
            if (state == FETCH && after_issue) begin
                flag_z <= zf;
                flag_s <= sf;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with a synchronous ROM and a small cpu flag model.
module tb_cpu_sequencer;

    localparam int PC_W      = 6;
    localparam int MAX_STEPS = 16;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [PC_W-1:0] prog_addr;
    logic [19:0]     prog_data = 20'h00000;
    logic [19:0]     instr;
    logic            zf = 1'b0;
    logic            sf = 1'b0;
    logic            flag_z;
    logic            flag_s;
    logic            busy;
    logic            done;
    logic            timeout;
    logic [1:0]      fsm_state;

    logic [19:0]     rom [0:63];
    logic [PC_W-1:0] fetch_q[$];
    logic [31:0]     exp_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_decode;
    int   n_issue;
    int   bad_instr;
    int   bad_busy;
    logic ended;
    logic saw_done;
    logic saw_to;
    logic end_busy;

    cpu_sequencer #(.PC_W(PC_W), .MAX_STEPS(MAX_STEPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .instr     (instr),
        .zf        (zf),
        .sf        (sf),
        .flag_z    (flag_z),
        .flag_s    (flag_s),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) prog_data <= rom[prog_addr];

    // cpu stand-in: flags from the low byte of an issued word; NOP clobbers zf.
    always @(posedge clk) begin
        if (instr != 20'h00000) begin
            zf <= (instr[7:0] == 8'h00);
            sf <= instr[7];
        end else begin
            zf <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 20'hF0000;
    endtask

    task automatic launch(input bit hold);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Monitors a run from its current cycle until done/timeout or the budget expires.
    task automatic watch(input int budget);
        fetch_q.delete();
        n_decode  = 0;
        n_issue   = 0;
        bad_instr = 0;
        bad_busy  = 0;
        ended     = 1'b0;
        saw_done  = 1'b0;
        saw_to    = 1'b0;
        end_busy  = 1'b1;
        for (int c = 0; c < budget && !ended; c++) begin
            if (fsm_state == 2'd1) fetch_q.push_back(prog_addr);
            if (fsm_state == 2'd2) n_decode++;
            if (instr != 20'h00000) begin
                n_issue++;
                if (fsm_state != 2'd3) bad_instr++;
            end
            if (done || timeout) begin
                ended    = 1'b1;
                saw_done = done;
                saw_to   = timeout;
                end_busy = busy;
            end else begin
                if (!busy) bad_busy++;
                tick();
            end
        end
        check("run_ended", 32'(ended), 32'd1);
        check("busy_during_run", bad_busy, 0);
        check("instr_only_in_issue", bad_instr, 0);
    endtask

    task automatic check_trace(input string tag);
        check({tag, "_len"}, fetch_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < fetch_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(fetch_q[i]), exp_q[i]);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int hits;
        clear_rom();

        // Reset values
        #3;
        check("rst_busy", busy, 0);
        check("rst_instr", instr, 0);
        check("rst_addr", prog_addr, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_flags", {flag_z, flag_s}, 0);
        check("rst_state", fsm_state, 0);
        #9 rst_n = 1'b1;
        tick();

        // LOAD then HALT: exact cycle timing
        rom[0] = 20'h10105;
        rom[1] = 20'hF0000;
        launch(0);
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("t1_instr_c%0d", c), instr, (c == 3) ? 32'h10105 : 32'h0);
            check($sformatf("t1_busy_c%0d", c), busy, (c <= 5) ? 32'd1 : 32'd0);
            check($sformatf("t1_done_c%0d", c), done, (c == 6) ? 32'd1 : 32'd0);
            tick();
        end

        // JZ taken after a zero result
        clear_rom();
        rom[0] = 20'h10800;
        rom[1] = 20'hA0004;
        rom[2] = 20'hF0000;
        rom[4] = 20'hF0000;
        launch(0);
        watch(100);
        exp_q = '{32'd0, 32'd1, 32'd4};
        hits = 0;
        foreach (fetch_q[i]) if (fetch_q[i] == 6'd2) hits++;
        check_trace("jz_trace");
        check("jz_addr2_never", hits, 0);
        check("jz_done", saw_done, 1);
        check("jz_flag_z", flag_z, 1);
        check("jz_flag_s", flag_s, 0);

        // JS not taken on a positive result
        clear_rom();
        rom[0] = 20'h1017F;
        rom[1] = 20'hE0005;
        launch(0);
        watch(100);
        exp_q = '{32'd0, 32'd1, 32'd2};
        check_trace("js0_trace");
        check("js0_done", saw_done, 1);
        check("js0_flag_s", flag_s, 0);
        check("js0_flag_z", flag_z, 0);

        // JS taken on a negative result
        rom[0] = 20'h10180;
        launch(0);
        watch(100);
        exp_q = '{32'd0, 32'd1, 32'd5};
        check_trace("js1_trace");
        check("js1_done", saw_done, 1);
        check("js1_flag_s", flag_s, 1);
        check("js1_flag_z", flag_z, 0);

        // Watchdog on a JMP-to-self loop
        clear_rom();
        rom[0] = 20'h90000;
        launch(0);
        watch(200);
        check("wd_timeout", saw_to, 1);
        check("wd_no_done", saw_done, 0);
        check("wd_decodes", n_decode, MAX_STEPS + 1);
        check("wd_no_issue", n_issue, 0);
        check("wd_busy_falls", end_busy, 0);
        check("wd_state_idle", fsm_state, 0);
        tick();
        check("wd_pulse_one_cycle", timeout, 0);

        // Asynchronous reset in the middle of an ISSUE cycle
        clear_rom();
        rom[0] = 20'h10180;
        rom[1] = 20'h10105;
        rom[2] = 20'hF0000;
        launch(0);
        for (int c = 1; c < 6; c++) tick();
        check("ar_pre_state", fsm_state, 3);
        check("ar_pre_instr", instr, 32'h10105);
        check("ar_pre_flag_s", flag_s, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_instr", instr, 0);
        check("ar_busy", busy, 0);
        check("ar_state", fsm_state, 0);
        check("ar_flags", {flag_z, flag_s}, 0);
        check("ar_addr", prog_addr, 0);
        #1 rst_n = 1'b1;
        tick();
        launch(0);
        watch(100);
        exp_q = '{32'd0, 32'd1, 32'd2};
        check_trace("ar_rerun_trace");
        check("ar_rerun_done", saw_done, 1);
        check("ar_rerun_flag_s", flag_s, 0);

        // start held high: ignored while busy, restarts at done
        rom[0] = 20'h10105;
        rom[1] = 20'h10106;
        launch(1);
        watch(100);
        exp_q = '{32'd0, 32'd1, 32'd2};
        check_trace("hold_trace");
        check("hold_done", saw_done, 1);
        tick();
        check("hold_restart_busy", busy, 1);
        check("hold_restart_state", fsm_state, 1);
        check("hold_restart_addr", prog_addr, 0);
        start = 1'b0;
        watch(100);
        exp_q = '{32'd0, 32'd1, 32'd2};
        check_trace("hold_run2_trace");
        check("hold_run2_done", saw_done, 1);
        check("hold_run2_issues", n_issue, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
